// File: rtl/uart_pkg.sv
// uart_pkg: shared types and line levels for the UART transmit scheduler.
//   tx_state_e     : transmit FSM states (PARITY is only reachable when the
//                    scheduler is built with UART_TX_PARITY_EN)
//   UART_IDLE_LVL  : level of an idle line and of the stop bit
//   UART_START_LVL : level of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/grant bundle between NUM_REQ requesters and the
// shared UART transmitter.
//   req      : per-requester frame request, held until granted
//   req_data : packed bytes, slice i (DATA_W bits) belongs to req[i]
//   grant    : one-hot, combinational; req_data[i] is captured at that edge
// Modports: master = requester side, slave = scheduler side.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;

    modport master (output req, output req_data, input grant);
    modport slave  (input req, input req_data, output grant);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   grant  : one-hot of the winner (all zero when nothing requests)
//   winner : index of the winner
//   valid  : at least one request present
// The search starts at ptr and wraps, so the first requester at or after
// ptr wins.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic           valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmit line among NUM_REQ requesters,
// round-robin, one byte per grant. Bits advance only on tx_tick.
//   clk, rst : clock, asynchronous active-high reset
//   tx_tick  : one-clk strobe per bit period from the baud generator
//   bus      : request/grant bundle (slave modport)
//   txd      : registered serial output, idle high
//   busy     : a frame is in progress
//   cur_id   : requester whose frame is on the line
//   done     : one-clk pulse on the tick that ends a stop bit
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_tick,
    uart_tx_sched_if.slave  bus,
    output logic            txd,
    output logic            busy,
    output logic [ID_W-1:0] cur_id,
    output logic            done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_winner;
    logic               arb_valid;
    logic               arb_slot;
    logic               last_bit;
    logic [DATA_W-1:0]  win_data;
    logic [ID_W-1:0]    ptr_next;
`ifdef UART_TX_PARITY_EN
    logic               par_q;
`endif

    rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .grant  (arb_grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // A new frame may only start from IDLE or at the end of a stop bit,
    // which is what lets frames run back-to-back without an idle gap.
    assign arb_slot = (state_q == IDLE) || (state_q == STOP);
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign win_data = bus.req_data[arb_winner*DATA_W +: DATA_W];
    assign ptr_next = (arb_winner == ID_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tx_tick) begin
            case (state_q)
                IDLE:  if (arb_valid) state_d = START;
                START: state_d = DATA;
                DATA: begin
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: state_d = STOP;
`endif
                STOP:    state_d = arb_valid ? START : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // grant and done are combinational strobes of the tick cycle; both are
    // held low while reset is asserted.
    always_comb begin
        bus.grant = '0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        if (!rst && tx_tick && arb_slot)          bus.grant = arb_grant;
        if (!rst && tx_tick && state_q == STOP)   done      = 1'b1;
    end

    // The start bit goes out on the grant tick itself; the shift register
    // then feeds bit 0 on the START tick and shifts on each DATA tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= UART_IDLE_LVL;
            shreg   <= '0;
            bit_cnt <= '0;
            cur_id  <= '0;
            ptr     <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (tx_tick) begin
            case (state_q)
                IDLE, STOP: begin
                    if (arb_valid) begin
                        shreg  <= win_data;
                        cur_id <= arb_winner;
                        ptr    <= ptr_next;
                        txd    <= UART_START_LVL;
`ifdef UART_TX_PARITY_EN
                        par_q  <= ^win_data;
`endif
                    end else begin
                        txd <= UART_IDLE_LVL;
                    end
                end
                START: begin
                    txd     <= shreg[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (!last_bit) begin
                        shreg   <= shreg >> 1;
                        txd     <= shreg[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd <= par_q;
`else
                        txd <= UART_IDLE_LVL;
`endif
                    end
                end
                default: txd <= UART_IDLE_LVL;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched (NUM_REQ=4,
// DATA_W=8). A queue-based line model predicts txd/busy/cur_id/grant/done
// every clock; a vector table covers a single 0xA5 frame; hand sequences
// cover reset, round-robin order, pointer wrap and mid-frame reset.
// Honours UART_TX_PARITY_EN to match the design build.
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_TICKS = DATA_W + 3;
    bit a5_lv [FRAME_TICKS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int FRAME_TICKS = DATA_W + 2;
    bit a5_lv [FRAME_TICKS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [DATA_W-1:0]  data;
        logic [NUM_REQ-1:0] exp_grant;
        logic               exp_done;
        logic               exp_txd;
        logic               exp_busy;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            tx_tick;
    logic            txd;
    logic            busy;
    logic            done;
    logic [ID_W-1:0] cur_id;

    logic [NUM_REQ-1:0] req_v;
    logic [DATA_W-1:0]  data_v [NUM_REQ];
    bit                 persist [NUM_REQ];

    int  m_q[$];
    bit  m_active;
    bit  m_level;
    int  m_ptr;
    int  m_cur;
    int  grant_log[$];
    int  pend_win;
    logic [NUM_REQ-1:0] smp_grant;
    logic               smp_done;

    int checks = 0;
    int errors = 0;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_tick (tx_tick),
        .bus     (bus),
        .txd     (txd),
        .busy    (busy),
        .cur_id  (cur_id),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign bus.req = req_v;
    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = data_v[i];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_level  = 1'b1;
        m_ptr    = 0;
        m_cur    = 0;
    endtask

    // Called at posedge+1; drives tick for one clock, checks at the negedge,
    // advances the model and applies the requester handshake after the edge.
    task automatic applyStimulus(input bit tick);
        bit boundary;
        int win;
        logic [31:0] exp_grant;
        tx_tick = tick;
        @(negedge clk);
        boundary = (m_q.size() == 0);
        win = -1;
        if (tick && boundary)
            for (int k = 0; k < NUM_REQ; k++)
                if (win < 0 && req_v[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        exp_grant = (win >= 0) ? (32'd1 << win) : 32'd0;
        smp_grant = bus.grant;
        smp_done  = done;
        checkOutput("grant", 32'(bus.grant), exp_grant);
        checkOutput("done", 32'(done), 32'(tick && boundary && m_active));
        checkOutput("txd", 32'(txd), 32'(m_level));
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("cur_id", 32'(cur_id), 32'(m_cur));
        if (tick) begin
            if (!boundary) begin
                m_level = m_q.pop_front() != 0;
            end else if (win >= 0) begin
                m_q.delete();
                for (int b = 0; b < DATA_W; b++) m_q.push_back(int'(data_v[win][b]));
`ifdef UART_TX_PARITY_EN
                m_q.push_back(int'(^data_v[win]));
`endif
                m_q.push_back(1);
                m_level  = 1'b0;
                m_active = 1'b1;
                m_cur    = win;
                m_ptr    = (win + 1) % NUM_REQ;
                grant_log.push_back(win);
            end else begin
                m_active = 1'b0;
                m_level  = 1'b1;
            end
        end
        pend_win = win;
        @(posedge clk);
        #1;
        if (pend_win >= 0) begin
            if (persist[pend_win]) data_v[pend_win] = 8'($urandom);
            else req_v[pend_win] = 1'b0;
        end
    endtask

    task automatic do_reset();
        tx_tick = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_txd", 32'(txd), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cur_id", 32'(cur_id), 32'd0);
        checkOutput("rst_grant", 32'(bus.grant), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_until_grants(input int n, input int period);
        int start;
        int cyc;
        start = grant_log.size();
        cyc = 0;
        while (grant_log.size() < start + n && cyc < 3000) begin
            applyStimulus(cyc % period == 0);
            cyc++;
        end
        if (grant_log.size() < start + n) checkOutput("grant_timeout", 32'(grant_log.size() - start), 32'(n));
    endtask

    task automatic drain();
        int cyc;
        for (int i = 0; i < NUM_REQ; i++) persist[i] = 1'b0;
        cyc = 0;
        while ((req_v != '0 || m_active) && cyc < 5000) begin
            applyStimulus(cyc % 2 == 0);
            cyc++;
        end
        if (req_v != '0 || m_active) checkOutput("drain_timeout", 32'(m_active), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl [FRAME_TICKS+1];
        int base;
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_ct [3] = '{1, 0, 1};

        rst = 1'b0;
        tx_tick = 1'b0;
        req_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_v[i]  = '0;
            persist[i] = 1'b0;
        end
        model_reset();
        #2;
        do_reset();

        // idle line, tick every 4 clocks, no requests
        for (int c = 0; c < 16; c++) applyStimulus(c % 4 == 0);

        // single 0xA5 frame from requester 2, table driven
        for (int k = 0; k <= FRAME_TICKS; k++) begin
            tbl[k].req       = (k == 0) ? 4'b0100 : 4'b0000;
            tbl[k].data      = 8'hA5;
            tbl[k].exp_grant = (k == 0) ? 4'b0100 : 4'b0000;
            tbl[k].exp_done  = (k == FRAME_TICKS);
            tbl[k].exp_txd   = (k < FRAME_TICKS) ? a5_lv[k] : 1'b1;
            tbl[k].exp_busy  = (k < FRAME_TICKS);
        end
        for (int k = 0; k <= FRAME_TICKS; k++) begin
            req_v     = tbl[k].req;
            data_v[2] = tbl[k].data;
            applyStimulus(1'b1);
            checkOutput("tbl_grant", 32'(smp_grant), 32'(tbl[k].exp_grant));
            checkOutput("tbl_done", 32'(smp_done), 32'(tbl[k].exp_done));
            checkOutput("tbl_txd", 32'(txd), 32'(tbl[k].exp_txd));
            checkOutput("tbl_busy", 32'(busy), 32'(tbl[k].exp_busy));
            if (k == 0) checkOutput("tbl_cur_id", 32'(cur_id), 32'd2);
            for (int g = 0; g < 3; g++) applyStimulus(1'b0);
        end

        // round robin with every requester re-presenting after each grant
        do_reset();
        req_v = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_v[i]  = 8'($urandom);
            persist[i] = 1'b1;
        end
        base = grant_log.size();
        run_until_grants(5, 2);
        for (int i = 0; i < 5; i++)
            if (grant_log.size() > base + i) checkOutput("rr_order", 32'(grant_log[base+i]), 32'(exp_rr[i]));
        drain();

        // contention after the pointer has moved past requester 1
        do_reset();
        base = grant_log.size();
        req_v = 4'b0010;
        data_v[1] = 8'h3C;
        run_until_grants(1, 3);
        req_v = 4'b0011;
        data_v[0] = 8'h81;
        data_v[1] = 8'h7E;
        run_until_grants(2, 3);
        for (int i = 0; i < 3; i++)
            if (grant_log.size() > base + i) checkOutput("wrap_order", 32'(grant_log[base+i]), 32'(exp_ct[i]));
        drain();

        // reset in the middle of a frame (data bit 3 of requester 1)
        do_reset();
        req_v = 4'b0010;
        data_v[1] = 8'h00;
        run_until_grants(1, 2);
        for (int t = 0; t < 4; t++) applyStimulus(1'b1);
        checkOutput("mid_txd_low", 32'(txd), 32'd0);
        req_v[0] = 1'b1;
        data_v[0] = 8'h5A;
        #2;
        rst = 1'b1;
        tx_tick = 1'b1;
        #1;
        checkOutput("async_txd", 32'(txd), 32'd1);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_cur_id", 32'(cur_id), 32'd0);
        checkOutput("async_grant", 32'(bus.grant), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_tick = 1'b0;
        model_reset();
        base = grant_log.size();
        run_until_grants(1, 2);
        if (grant_log.size() > base) checkOutput("post_rst_grant", 32'(grant_log[base]), 32'd0);
        checkOutput("post_rst_cur_id", 32'(cur_id), 32'd0);
        drain();

        // randomized traffic with random tick spacing
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 7) == 0) begin
                    req_v[i]   = 1'b1;
                    data_v[i]  = 8'($urandom);
                    persist[i] = ($urandom_range(0, 1) == 1);
                end else if (req_v[i] && $urandom_range(0, 63) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            applyStimulus($urandom_range(0, 2) == 0);
        end
        drain();

`ifdef UART_TX_PARITY_EN
        // parity bit for 0x07 (odd weight) and 0x03 (even weight)
        for (int p = 0; p < 2; p++) begin
            logic lv [FRAME_TICKS];
            req_v = 4'b0001;
            data_v[0] = (p == 0) ? 8'h07 : 8'h03;
            for (int t = 0; t < FRAME_TICKS; t++) begin
                applyStimulus(1'b1);
                lv[t] = txd;
            end
            applyStimulus(1'b1);
            checkOutput("par_bit", 32'(lv[DATA_W+1]), (p == 0) ? 32'd1 : 32'd0);
            checkOutput("par_stop", 32'(lv[DATA_W+2]), 32'd1);
            checkOutput("par_done", 32'(smp_done), 32'd1);
            applyStimulus(1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
